// File: rtl/fifo_rd.sv
// Synchronous FIFO with a request-driven read port: the consumer asks for a pop
// with r_valid and the FIFO answers with r_ready. Optional empty-FIFO fall-through.
module fifo_rd #(
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       srst,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       r_valid,
  output logic                       r_ready,
  output logic [WIDTH-1:0]           r_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int  AW      = $clog2(DEPTH);
  localparam int  PW      = AW + 1;
  localparam int  CW      = $clog2(DEPTH+1);
  localparam bit  USE_BYP = (BYPASS != 0);

  // Handshake: a write fires on w_valid & w_ready, a read fires on r_valid & r_ready.
  // Either side may raise its valid in any cycle; nothing is committed without its ready.
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    ptr_diff;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             full;
  logic             byp_hit;
  logic             w_fire;
  logic             r_fire;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign ptr_diff = wptr - rptr;

  // Fall-through only exists on an empty FIFO; otherwise the head entry is older.
  assign byp_hit  = USE_BYP && empty && w_valid;

  assign w_ready  = ~full;
  assign r_ready  = ~empty | byp_hit;
  assign r_data   = byp_hit ? w_data : mem[rptr[AW-1:0]];
  assign count    = CW'(ptr_diff);

  assign w_fire   = w_valid & w_ready;
  assign r_fire   = r_valid & r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (srst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (w_fire) wptr <= wptr + PW'(1);
      if (r_fire) rptr <= rptr + PW'(1);
    end
  end

  // Storage is never reset; a bypassed entry is written too, but rptr moves past it.
  always_ff @(posedge clk) begin
    if (w_fire && !srst) mem[wptr[AW-1:0]] <= w_data;
  end

endmodule

// File: doc/fifo_rd.md
# fifo_rd

Synchronous FIFO of parameterised depth whose read port is request-driven: the consumer asserts `r_valid` to request a pop, and the FIFO answers with `r_ready` when data is available. It is the read-side counterpart of the single-entry write-driven FIFO. It buffers between a free-running producer and a consumer that pulls entries on demand, such as a response queue drained by a bus responder. An optional fall-through path gives zero-latency delivery when the buffer is empty.

## Interface

Parameters:

- `WIDTH`, default 1: data width in bits.
- `DEPTH`, default 4: number of entries. Must be a power of 2 and at least 2.
- `BYPASS`, default 0: when 1 and the FIFO is empty, `w_data` falls through combinationally to the read port.

Ports (one clock; reset is asynchronous and active-low):

- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `srst`, input, 1: synchronous reset. Takes priority over all transfers.
- `w_valid`, input, 1: producer offers `w_data`.
- `w_ready`, output, 1: FIFO can accept a write.
- `w_data`, input, WIDTH: write data.
- `r_valid`, input, 1: consumer requests a pop.
- `r_ready`, output, 1: data is available on `r_data`.
- `r_data`, output, WIDTH: read data. Valid only while `r_ready=1`.
- `count`, output, $clog2(DEPTH+1): current occupancy, 0..DEPTH.

## Operation

Pointers:

- `wptr` and `rptr` are each $clog2(DEPTH)+1 bits wide. The low bits index the memory; the MSB is a phase bit.
- Empty: `wptr == rptr`.
- Full: the low bits are equal and the phase bits differ.
- Both pointers wrap naturally, modulo 2·DEPTH.

Transfers:

- A write fires when `w_valid & w_ready`. It stores `w_data` at `mem[wptr]` and increments `wptr`.
- A read fires when `r_valid & r_ready`. It increments `rptr`.

Handshake outputs:

- `w_ready = ~full`. There is no write skid: when full, a write is blocked even if a read fires in the same cycle.
- `r_ready = ~empty`, or `~empty | w_valid` when BYPASS=1.
- `r_data = mem[rptr]`. When BYPASS=1 and the FIFO is empty, `r_data = w_data` instead.

Occupancy:

- `count = wptr - rptr`, computed modulo 2·DEPTH and zero-extended to the output width.

Boundary cases:

- **Simultaneous read and write, not full and not empty:** both pointers advance and `count` is unchanged.
- **Bypass on empty, both sides fire:** both pointers advance. The memory write is harmless and `count` stays 0. The consumer receives `w_data` in the same cycle.
- **Bypass on empty, write only:** normal enqueue. `count` becomes 1.
- **Read requested while empty without bypass:** `r_ready=0`. The request is ignored; no state changes and no error.
- **Write offered while full:** `w_ready=0`. The data is dropped, and the producer must hold it.
- **`srst=1`:** both pointers clear to 0 at the next edge. Transfers in that cycle are discarded; memory contents are irrelevant.
- **`rst_n` low mid-operation:** pointers clear immediately (asynchronously) and all in-flight entries are lost.
- **Memory:** not reset. `r_data` is don't-care while `r_ready=0`.

## Timing

- Reset values (on `rst_n` low or after `srst`):
  - `w_ready=1`, `count=0`.
  - `r_ready=0` (BYPASS=0), or `r_ready=w_valid` (BYPASS=1).
  - `r_data` undefined except in bypass.
- Write-to-read latency:
  - 1 cycle: data written at edge N is visible with `r_ready=1` in the cycle after edge N.
  - 0 cycles with BYPASS=1 on an empty FIFO.
- `w_ready`, `r_ready` and `count` are combinational from registered pointers. The only exceptions are the BYPASS terms in `r_ready` and `r_data`, which are combinational from `w_valid` and `w_data`.
- Throughput: one write and one read per cycle, sustained.
- `r_valid` may be asserted in any cycle. The consumer need not wait for `r_ready`.

## Test plan

- **Fill and drain (DEPTH=4, BYPASS=0):**
  - Write 0xA0..0xA3 on 4 consecutive cycles, then `w_ready=0` and `count=4`.
  - Assert `r_valid` for 4 cycles, then `r_data` yields 0xA0, 0xA1, 0xA2, 0xA3 in order, ending with `count=0` and `r_ready=0`.
- **Full with simultaneous read and write:** with 4 entries held, assert `w_valid=1` and `r_valid=1` for one cycle. The read of the head entry completes, the write is blocked, and `count=3`.
- **Wrap-around:** stream 20 writes (0x00..0x13) with a read every cycle after the first. The output order is exact, `count` stays 1, and no data is lost across pointer wrap.
- **Bypass (BYPASS=1):**
  - With the FIFO empty, `w_valid=1`, `w_data=0x5A` and `r_valid=1` give `r_ready=1` and `r_data=0x5A` in the same cycle; `count` stays 0.
  - The same stimulus without `r_valid` gives `count=1`.
- **`srst` mid-operation:** with `count=3`, pulse `srst` together with `w_valid=1` and `r_valid=1`. The next cycle shows `count=0`, `r_ready=0` and `w_ready=1`, and the write is discarded.
- **Async reset:** with `count=2`, drop `rst_n` between clock edges. `count=0` and `w_ready=1` take effect immediately, without waiting for a clock edge.
